// File: rtl/dl_reg_pipe_if.sv
// dl_reg_pipe_if
//   Bundles the data/control signals of one dl_reg_pipe instance.
//   Clock and reset are not part of the bundle; they stay plain ports on
//   the pipe itself.
//
//   en     : pipeline advances on this edge (1) or holds (0)
//   clr    : synchronous clear of all stages, wins over en
//   d      : data word captured at posedge
//   d_vld  : valid flag travelling with d
//   q      : last-stage data
//   q_vld  : last-stage valid flag
//   q_chg  : one-cycle pulse, q changed at the previous edge
//
//   master : the side that drives d/controls and observes q
//   slave  : the pipe itself
interface dl_reg_pipe_if #(
  parameter int unsigned NUM_BITS = 32
);
  logic                en;
  logic                clr;
  logic [NUM_BITS-1:0] d;
  logic                d_vld;
  logic [NUM_BITS-1:0] q;
  logic                q_vld;
  logic                q_chg;

  modport master (
    output en, clr, d, d_vld,
    input  q, q_vld, q_chg
  );

  modport slave (
    input  en, clr, d, d_vld,
    output q, q_vld, q_chg
  );
endinterface

// File: rtl/dl_reg_pipe.sv
// dl_reg_pipe
//   Generic D-register / register pipeline with load enable, synchronous
//   clear, a travelling valid flag and a value-change strobe. Used as the
//   flop stage for datapath retiming and pipeline registers.
//
//   Parameters
//     NUM_BITS   : data width (>= 1)
//     NUM_STAGES : register stages between d and q (>= 1)
//     RESET_VAL  : value loaded into every data stage on reset or clear
//
//   Ports
//     clk    : single clock, all state updates on posedge
//     rst_n  : asynchronous active-low reset
//     bus    : slave side of dl_reg_pipe_if (en, clr, d, d_vld in;
//              q, q_vld, q_chg out)
//
//   q is the last data stage, fully registered; there is no combinational
//   path from d to q.
module dl_reg_pipe #(
  parameter int unsigned         NUM_BITS   = 32,
  parameter int unsigned         NUM_STAGES = 1,
  parameter logic [NUM_BITS-1:0] RESET_VAL  = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  dl_reg_pipe_if.slave bus
);

  if (NUM_STAGES < 1) begin : g_bad_stages
    $error("dl_reg_pipe: NUM_STAGES must be >= 1");
  end

  if (NUM_BITS < 1) begin : g_bad_bits
    $error("dl_reg_pipe: NUM_BITS must be >= 1");
  end

  localparam int unsigned LAST = NUM_STAGES - 1;

  // Stage 0 is the capture stage, stage LAST drives q.
  logic [NUM_BITS-1:0] data_q   [NUM_STAGES];
  logic [NUM_BITS-1:0] data_nxt [NUM_STAGES];
  logic [NUM_STAGES-1:0] vld_q;
  logic [NUM_STAGES-1:0] vld_nxt;
  logic                  chg_q;
  logic                  chg_nxt;

  // Next state of the whole pipe: clr > en > hold.
  always_comb begin
    data_nxt = data_q;
    vld_nxt  = vld_q;
    if (bus.clr) begin
      for (int unsigned i = 0; i < NUM_STAGES; i++) begin
        data_nxt[i] = RESET_VAL;
      end
      vld_nxt = '0;
    end else if (bus.en) begin
      data_nxt[0] = bus.d;
      vld_nxt[0]  = bus.d_vld;
      for (int unsigned i = 1; i < NUM_STAGES; i++) begin
        data_nxt[i] = data_q[i-1];
        vld_nxt[i]  = vld_q[i-1];
      end
    end
  end

  // Change strobe compares the last stage before and after this edge, so a
  // clear that actually alters q also pulses it. Inequality (not !==) keeps
  // X on d visible on the strobe instead of masking it.
  always_comb begin
    chg_nxt = (data_nxt[LAST] != data_q[LAST]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_STAGES; i++) begin
        data_q[i] <= RESET_VAL;
      end
      vld_q <= '0;
      chg_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_STAGES; i++) begin
        data_q[i] <= data_nxt[i];
      end
      vld_q <= vld_nxt;
      chg_q <= chg_nxt;
    end
  end

  assign bus.q     = data_q[LAST];
  assign bus.q_vld = vld_q[LAST];
  assign bus.q_chg = chg_q;

endmodule

// File: tb/tb_dl_reg_pipe.sv
// tb_dl_reg_pipe
//   Drives a 1-stage and a 3-stage dl_reg_pipe with identical stimulus and
//   compares both against a history-based reference: q of an N-stage pipe is
//   the N-th most recent word captured since the last reset/clear, or the
//   reset value if fewer than N words have been captured.
module tb_dl_reg_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        clr;
  logic [31:0] d;
  logic        d_vld;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;  // posedges at 5, 15, 25, ...

  dl_reg_pipe_if #(.NUM_BITS(32)) b1 ();
  dl_reg_pipe_if #(.NUM_BITS(32)) b3 ();

  assign b1.en = en;  assign b1.clr = clr;  assign b1.d = d;  assign b1.d_vld = d_vld;
  assign b3.en = en;  assign b3.clr = clr;  assign b3.d = d;  assign b3.d_vld = d_vld;

  dl_reg_pipe #(.NUM_BITS(32), .NUM_STAGES(1), .RESET_VAL(32'h0)) u_pipe1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1)
  );

  dl_reg_pipe #(.NUM_BITS(32), .NUM_STAGES(3), .RESET_VAL(32'h0)) u_pipe3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b3)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // hist holds {vld, data} of every word captured since the last reset/clear,
  // newest at the back.
  logic [32:0] hist [$];
  logic        exp_chg1;
  logic        exp_chg3;

  function automatic logic [32:0] exp_at(input int n);
    if (hist.size() >= n) return hist[hist.size() - n];
    return 33'h0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic [31:0] old1;
    logic [31:0] old3;
    logic [32:0] now1;
    logic [32:0] now3;
    if (!rst_n) begin
      hist.delete();
      exp_chg1 = 1'b0;
      exp_chg3 = 1'b0;
    end else begin
      now1 = exp_at(1);
      now3 = exp_at(3);
      old1 = now1[31:0];
      old3 = now3[31:0];
      if (clr) hist.delete();
      else if (en) hist.push_back({d_vld, d});
      if (hist.size() > 8) void'(hist.pop_front());
      now1 = exp_at(1);
      now3 = exp_at(3);
      exp_chg1 = (now1[31:0] != old1);
      exp_chg3 = (now3[31:0] != old3);
    end
  end

  // Continuous scoreboard, sampled away from the active edge.
  always @(negedge clk) begin
    logic [32:0] e1;
    logic [32:0] e3;
    e1 = exp_at(1);
    e3 = exp_at(3);
    check("sb_q1",     64'(b1.q),     64'(e1[31:0]));
    check("sb_vld1",   64'(b1.q_vld), 64'(e1[32]));
    check("sb_chg1",   64'(b1.q_chg), 64'(exp_chg1));
    check("sb_q3",     64'(b3.q),     64'(e3[31:0]));
    check("sb_vld3",   64'(b3.q_vld), 64'(e3[32]));
    check("sb_chg3",   64'(b3.q_chg), 64'(exp_chg3));
  end

  // One edge, then settle on the falling edge for checks/new inputs.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic e, input logic c, input logic [31:0] dv, input logic v);
    en = e; clr = c; d = dv; d_vld = v;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned t_end;
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1);
    repeat (3) step();
    check("rst_q1",   64'(b1.q),     64'h0);
    check("rst_vld1", 64'(b1.q_vld), 64'h0);
    check("rst_chg1", 64'(b1.q_chg), 64'h0);
    check("rst_q3",   64'(b3.q),     64'h0);

    // Capture and change strobe.
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1);
    step();
    check("cap_q1",   64'(b1.q),     64'hDEAD_BEEF);
    check("cap_vld1", 64'(b1.q_vld), 64'h1);
    check("cap_chg1", 64'(b1.q_chg), 64'h1);
    step();
    check("same_chg1", 64'(b1.q_chg), 64'h0);

    // Hold, then clear with en still high.
    drive(1'b0, 1'b0, 32'h1234_5678, 1'b1);
    step();
    check("hold_q1",   64'(b1.q),     64'hDEAD_BEEF);
    check("hold_chg1", 64'(b1.q_chg), 64'h0);
    drive(1'b1, 1'b1, 32'h1234_5678, 1'b1);
    step();
    check("clr_q1",   64'(b1.q),     64'h0);
    check("clr_vld1", 64'(b1.q_vld), 64'h0);
    check("clr_chg1", 64'(b1.q_chg), 64'h1);
    check("clr_q3",   64'(b3.q),     64'h0);

    // Latency through three stages, with a two-edge stall mid-stream.
    for (int unsigned i = 1; i <= 4; i++) begin
      drive(1'b1, 1'b0, 32'(i), 1'b1);
      step();
      if (i < 3) check("lat_pre_q3", 64'(b3.q), 64'h0);
      else       check("lat_q3",     64'(b3.q), 64'(i - 2));
    end
    drive(1'b0, 1'b0, 32'hAAAA_AAAA, 1'b0);
    repeat (2) begin
      step();
      check("stall_q3", 64'(b3.q), 64'h2);
    end
    for (int unsigned i = 5; i <= 6; i++) begin
      drive(1'b1, 1'b0, 32'(i), 1'b0);
      step();
      check("resume_q3", 64'(b3.q), 64'(i - 2));
    end

    // Asynchronous reset mid-cycle, observed before the next edge.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_q1",   64'(b1.q),     64'h0);
    check("arst_q3",   64'(b3.q),     64'h0);
    check("arst_vld3", 64'(b3.q_vld), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Random phase: d changes at random gaps (never on a posedge), controls
    // change at negedges; the scoreboard checks every cycle.
    t_end = 32'($time) + 5000;
    fork
      begin
        while ($time < t_end) begin
          #($urandom_range(1, 10));
          if (($time % 10) == 5) #1;
          d = $urandom;
        end
      end
      begin
        while ($time < t_end) begin
          @(negedge clk);
          en    = ($urandom_range(0, 3) != 0);
          clr   = ($urandom_range(0, 15) == 0);
          d_vld = $urandom_range(0, 1) != 0;
        end
      end
    join

    drive(1'b0, 1'b0, 32'h0, 1'b0);
    step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
